alu_divider: RTL and testbench
==============================

// Module: alu_divider
// PURPOSE
//  Sequential signed/unsigned integer divider, the inverse of the ALU multiply path.
//  Divides an N-bit or 2N-bit dividend ({ahigh,a}) by an N-bit divisor b.
//  Returns quotient in y and remainder in yhigh, with ALU-style flags.
//  Sits beside the ALU in the execute stage; the control unit stalls on busy.
// PARAMETERS
//  N   16   operand/result width in bits (N >= 4)
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   synchronous, active-high
//  start     in   1   request; sampled only in IDLE or DONE
//  a         in   N   dividend low word
//  ahigh     in   N   dividend high word (used only when use32bit=1)
//  b         in   N   divisor
//  signed_op in   1   1 = two's-complement operands, 0 = unsigned
//  use32bit  in   1   1 = 2N-bit dividend {ahigh,a}, 0 = N-bit dividend a
//  busy      out  1   operation in progress (PREP/RUN/FIX)
//  done      out  1   one-cycle pulse; results valid from this cycle
//  y         out  N   quotient (truncated toward zero)
//  yhigh     out  N   remainder; sign follows dividend
//  zero      out  1   y == 0
//  negative  out  1   y[N-1]
//  overflow  out  1   quotient not representable in N bits, or divide by zero
//  divzero   out  1   b == 0
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, y, yhigh and all flags = 0. Reset overrides any state and aborts in-flight work; no done pulse.
//  States: IDLE -> PREP -> RUN -> FIX -> DONE -> IDLE.
//   - Start from DONE goes directly to PREP.
//   - start is ignored in PREP/RUN/FIX.
//  Edge E0 (start=1 in IDLE/DONE): latch a, ahigh, b, signed_op, use32bit; go to PREP.
//   - Later input changes have no effect on the running operation.
//  PREP, one edge:
//   - if b==0, go to DONE: divzero=1, overflow=1, y=all ones, yhigh=latched a, zero=0, negative=1.
//   - else store |dividend| and |b| (magnitude only when signed_op), record signs, count=0, go to RUN.
//  RUN: one restoring-division step per edge: shift {rem,dvd} left 1; if rem >= |b|, rem -= |b| and quotient bit = 1.
//   - Runs K steps: K=N when use32bit=0, K=2N when use32bit=1.
//   - The internal quotient is K bits wide; rem is N+1 bits, so no loss.
//  FIX, one edge:
//   - qsign = dsign ^ bsign; apply negation to quotient if qsign and remainder if dsign (signed_op only).
//   - Register y = quotient[N-1:0] and yhigh = remainder[N-1:0]; set flags; go to DONE.
//  overflow, unsigned: true quotient > 2^N-1. overflow, signed: quotient outside [-2^(N-1), 2^(N-1)-1].
//   - On overflow, y holds the low N bits of the true quotient.
//  Dividend sign is ahigh[N-1] when use32bit=1, else a[N-1]. Remainder always fits in N bits.
//  zero=(y==0) and negative=y[N-1], both evaluated on final y.
//  busy=1 in PREP, RUN and FIX only. done=1 only in DONE, for exactly one cycle.
//   - y, yhigh and flags are held until the next FIX, or the PREP divzero exit.
//  Latency from E0 to done high:
//   - N+2 edges when use32bit=0 (18 at N=16).
//   - 2N+2 edges when use32bit=1 (34 at N=16).
//   - 2 edges on divide by zero.
//  Throughput: back-to-back start in the DONE cycle is accepted with no bubble.
// TESTING
//  1. Unsigned 16-bit, a=1000, b=7 -> y=0x008E, yhigh=0x0006, flags 0; done exactly 18 edges after start.
//  2. Signed, a=0xFFF9 (-7), b=0x0002 -> y=0xFFFD, yhigh=0xFFFF, negative=1, overflow=0.
//  3. Signed, a=0x8000, b=0xFFFF -> overflow=1, y=0x8000, yhigh=0x0000.
//  4. Unsigned 32-bit, {ahigh,a}=0x0001_0000, b=2 -> y=0x8000, overflow=0, done at 34 edges.
//     {ahigh,a}=0x0002_0000, b=2 -> overflow=1, y=0x0000, zero=1.
//  5. b=0 -> divzero=1, overflow=1, y=0xFFFF, yhigh=a; done 2 edges after start, busy high for 1 cycle.
//  6. Reset mid-RUN -> busy=0, done=0, y=0 next edge, no done pulse.
//     start pulsed while busy -> ignored.
//     start held across DONE -> second result correct, no idle cycle.

Source files
------------

// File: rtl/alu_divider.sv
// Sequential restoring divider beside the ALU: N- or 2N-bit dividend by an N-bit divisor,
// signed or unsigned, quotient in y, remainder in yhigh, with ALU-style flags.
module alu_divider #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] ahigh,
  input  logic [N-1:0] b,
  input  logic         signed_op,
  input  logic         use32bit,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic [N-1:0] yhigh,
  output logic         zero,
  output logic         negative,
  output logic         overflow,
  output logic         divzero,
  output logic [2:0]   dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); busy stays high until
  // the single-cycle done pulse, and y/yhigh/flags are valid from that cycle until the next result.
  localparam int CW = $clog2(2 * N + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, ahigh_q, ahigh_d, b_q, b_d;
  logic           sgn_q, sgn_d, w32_q, w32_d;
  logic [N:0]     rem_q, rem_d;
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [N-1:0]   bmag_q, bmag_d;
  logic           dsign_q, dsign_d, bsign_q, bsign_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   y_q, y_d, yhigh_q, yhigh_d;
  logic           zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d, dz_q, dz_d;

  logic           dsign_n, bsign_n;
  logic [N-1:0]   bmag_n, lo_mag;
  logic [2*N-1:0] full_val, full_mag, dvd_init;
  logic [3*N:0]   prep_step, run_step;
  logic [CW-1:0]  k_last;
  logic [2*N-1:0] qmag, qval, half;
  logic           qsign, ovf_n;
  logic [N-1:0]   rem_n, yq_n;

  // One restoring step: shift {rem,dvd} left, subtract the divisor if it fits, shift in the quotient bit.
  function automatic logic [3*N:0] div_step(input logic [N:0] rem, input logic [2*N-1:0] dvd,
                                            input logic [N-1:0] bmag);
    logic [N:0]     sh;
    logic [2*N-1:0] nd;
    sh = {rem[N-1:0], dvd[2*N-1]};
    nd = {dvd[2*N-2:0], 1'b0};
    if (sh >= {1'b0, bmag}) begin
      sh    = sh - {1'b0, bmag};
      nd[0] = 1'b1;
    end
    return {sh, nd};
  endfunction

  always_comb begin
    dsign_n   = sgn_q & (w32_q ? ahigh_q[N-1] : a_q[N-1]);
    bsign_n   = sgn_q & b_q[N-1];
    bmag_n    = bsign_n ? -b_q : b_q;
    full_val  = {ahigh_q, a_q};
    full_mag  = dsign_n ? -full_val : full_val;
    lo_mag    = dsign_n ? -a_q : a_q;
    dvd_init  = w32_q ? full_mag : {lo_mag, {N{1'b0}}};
    // PREP already performs the first step, so RUN needs only K-1 more edges.
    prep_step = div_step({(N+1){1'b0}}, dvd_init, bmag_n);
    run_step  = div_step(rem_q, dvd_q, bmag_q);
    k_last    = w32_q ? CW'(2 * N - 1) : CW'(N - 1);

    qmag      = w32_q ? dvd_q : {{N{1'b0}}, dvd_q[N-1:0]};
    qsign     = dsign_q ^ bsign_q;
    qval      = qsign ? -qmag : qmag;
    half      = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
    ovf_n     = sgn_q ? (qsign ? (qmag > half) : (qmag >= half)) : (|qmag[2*N-1:N]);
    rem_n     = dsign_q ? -rem_q[N-1:0] : rem_q[N-1:0];
    yq_n      = qval[N-1:0];

    state_d = state_q;
    a_d     = a_q;     ahigh_d = ahigh_q; b_d = b_q;
    sgn_d   = sgn_q;   w32_d   = w32_q;
    rem_d   = rem_q;   dvd_d   = dvd_q;   bmag_d = bmag_q;
    dsign_d = dsign_q; bsign_d = bsign_q; cnt_d  = cnt_q;
    y_d     = y_q;     yhigh_d = yhigh_q;
    zero_d  = zero_q;  neg_d   = neg_q;   ovf_d  = ovf_q; dz_d = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          ahigh_d = ahigh;
          b_d     = b;
          sgn_d   = signed_op;
          w32_d   = use32bit;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (b_q == '0) begin
          y_d     = '1;
          yhigh_d = a_q;
          zero_d  = 1'b0;
          neg_d   = 1'b1;
          ovf_d   = 1'b1;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          {rem_d, dvd_d} = prep_step;
          bmag_d  = bmag_n;
          dsign_d = dsign_n;
          bsign_d = bsign_n;
          cnt_d   = CW'(1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        {rem_d, dvd_d} = run_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == k_last) state_d = S_FIX;
      end
      S_FIX: begin
        y_d     = yq_n;
        yhigh_d = rem_n;
        zero_d  = (yq_n == '0);
        neg_d   = yq_n[N-1];
        ovf_d   = ovf_n;
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q <= '0; ahigh_q <= '0; b_q <= '0;
      sgn_q <= 1'b0; w32_q <= 1'b0;
      rem_q <= '0; dvd_q <= '0; bmag_q <= '0;
      dsign_q <= 1'b0; bsign_q <= 1'b0; cnt_q <= '0;
      y_q <= '0; yhigh_q <= '0;
      zero_q <= 1'b0; neg_q <= 1'b0; ovf_q <= 1'b0; dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; ahigh_q <= ahigh_d; b_q <= b_d;
      sgn_q <= sgn_d; w32_q <= w32_d;
      rem_q <= rem_d; dvd_q <= dvd_d; bmag_q <= bmag_d;
      dsign_q <= dsign_d; bsign_q <= bsign_d; cnt_q <= cnt_d;
      y_q <= y_d; yhigh_q <= yhigh_d;
      zero_q <= zero_d; neg_q <= neg_d; ovf_q <= ovf_d; dz_q <= dz_d;
    end
  end

  assign busy      = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign y         = y_q;
  assign yhigh     = yhigh_q;
  assign zero      = zero_q;
  assign negative  = neg_q;
  assign overflow  = ovf_q;
  assign divzero   = dz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_divider.sv
// Bench for alu_divider: directed cases, randomized operations against an arithmetic model,
// reset abort, start while busy and back-to-back starts.
module tb_alu_divider;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, ahigh, b;
  logic        signed_op, use32bit;
  logic        busy, done, zero, negative, overflow, divzero;
  logic [15:0] y, yhigh;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  alu_divider #(.N(16)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .ahigh(ahigh), .b(b),
    .signed_op(signed_op), .use32bit(use32bit), .busy(busy), .done(done),
    .y(y), .yhigh(yhigh), .zero(zero), .negative(negative), .overflow(overflow),
    .divzero(divzero), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Result vector layout: {y, yhigh, zero, negative, overflow, divzero}
  function automatic logic [35:0] model(input logic [15:0] ma, mah, mb, input logic ms, mw);
    longint d, dv, q, r;
    logic [15:0] yq, yr;
    logic ov;
    if (mb == 16'd0) return {16'hFFFF, ma, 4'b0111};
    if (ms) begin
      d  = mw ? longint'($signed({mah, ma})) : longint'($signed(ma));
      dv = longint'($signed(mb));
    end else begin
      d  = mw ? longint'({mah, ma}) : longint'(ma);
      dv = longint'(mb);
    end
    q  = d / dv;
    r  = d % dv;
    ov = ms ? (q < -32768 || q > 32767) : (q > 65535);
    yq = q[15:0];
    yr = r[15:0];
    return {yq, yr, (yq == 16'd0), yq[15], ov, 1'b0};
  endfunction

  function automatic int exp_lat(input logic [15:0] mb, input logic mw);
    if (mb == 16'd0) return 2;
    return mw ? 34 : 18;
  endfunction

  function automatic logic [35:0] obs_vec();
    return {y, yhigh, zero, negative, overflow, divzero};
  endfunction

  task automatic run_op(input logic [15:0] ta, tah, tb, input logic ts, tw,
                        output logic [35:0] obs, output int lat, output int bcnt);
    @(negedge clk);
    a = ta; ahigh = tah; b = tb; signed_op = ts; use32bit = tw; start = 1'b1;
    @(posedge clk); #1;
    lat  = 1;
    bcnt = (busy === 1'b1) ? 1 : 0;
    start = 1'b0;
    a = 16'($urandom); ahigh = 16'($urandom); b = 16'($urandom);
    signed_op = 1'($urandom_range(0, 1)); use32bit = 1'($urandom_range(0, 1));
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1 && busy === 1'b1) bcnt++;
    end
    obs = obs_vec();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    a = '0; ahigh = '0; b = '0; signed_op = 1'b0; use32bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, y, yhigh, zero, negative, overflow, divzero} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b y=%h yhigh=%h flags=%b%b%b%b, want all 0",
               busy, done, y, yhigh, zero, negative, overflow, divzero);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ta[6], tah[6], tb[6];
    logic        ts[6], tw[6];
    logic [35:0] want[6];
    int          wlat[6];
    logic [35:0] obs, e;
    int lat, bcnt;
    ta[0]=16'd1000;  tah[0]=16'h0; tb[0]=16'd7;    ts[0]=0; tw[0]=0; want[0]={16'h008E,16'h0006,4'b0000}; wlat[0]=18;
    ta[1]=16'hFFF9;  tah[1]=16'h0; tb[1]=16'h0002; ts[1]=1; tw[1]=0; want[1]={16'hFFFD,16'hFFFF,4'b0100}; wlat[1]=18;
    ta[2]=16'h8000;  tah[2]=16'h0; tb[2]=16'hFFFF; ts[2]=1; tw[2]=0; want[2]={16'h8000,16'h0000,4'b0110}; wlat[2]=18;
    ta[3]=16'h0000;  tah[3]=16'h1; tb[3]=16'd2;    ts[3]=0; tw[3]=1; want[3]={16'h8000,16'h0000,4'b0100}; wlat[3]=34;
    ta[4]=16'h0000;  tah[4]=16'h2; tb[4]=16'd2;    ts[4]=0; tw[4]=1; want[4]={16'h0000,16'h0000,4'b1010}; wlat[4]=34;
    ta[5]=16'h1234;  tah[5]=16'h5; tb[5]=16'd0;    ts[5]=0; tw[5]=0; want[5]={16'hFFFF,16'h1234,4'b0111}; wlat[5]=2;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(want[i]);
      run_op(ta[i], tah[i], tb[i], ts[i], tw[i], obs, lat, bcnt);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL directed_%0d_result: got %h, want %h", i, obs, e);
      end
      checks++;
      if (lat != wlat[i]) begin
        errors++;
        $display("FAIL directed_%0d_latency: got %0d edges, want %0d", i, lat, wlat[i]);
      end
      checks++;
      if (bcnt != wlat[i] - 1) begin
        errors++;
        $display("FAIL directed_%0d_busy_cycles: got %0d, want %0d", i, bcnt, wlat[i] - 1);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || obs_vec() !== e) begin
        errors++;
        $display("FAIL directed_%0d_done_pulse_hold: done=%b result=%h, want done=0 result=%h",
                 i, done, obs_vec(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rah, rb;
    logic rs, rw;
    logic [35:0] obs, e;
    int lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rah = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rb  = ($urandom_range(0, 7) == 0) ? 16'd0 :
            ($urandom_range(0, 1) == 1) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      rs  = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      exp_q.push_back(model(ra, rah, rb, rs, rw));
      run_op(ra, rah, rb, rs, rw, obs, lat, bcnt);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e || lat != exp_lat(rb, rw)) begin
        errors++;
        $display("FAIL random_%0d: a=%h ah=%h b=%h s=%b w=%b got %h lat %0d, want %h lat %0d",
                 i, ra, rah, rb, rs, rw, obs, lat, e, exp_lat(rb, rw));
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    @(negedge clk);
    a = 16'd5000; ahigh = 16'h0; b = 16'd3; signed_op = 1'b0; use32bit = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 16'd0 || yhigh !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b y=%h yhigh=%h, want 0 0 0000 0000",
               busy, done, y, yhigh);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_abort_no_done: got %0d active cycles after reset, want 0", pulses);
    end
  endtask

  task automatic test_start_while_busy();
    logic [35:0] e;
    int lat = 1, pulses = 0;
    exp_q.push_back(model(16'd40000, 16'h0, 16'd9, 1'b0, 1'b0));
    @(negedge clk);
    a = 16'd40000; ahigh = 16'h0; b = 16'd9; signed_op = 1'b0; use32bit = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    a = 16'd77; b = 16'd0; use32bit = 1'b1; start = 1'b1;
    @(posedge clk); #1; lat++; start = 1'b0;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== e || lat != 18) begin
      errors++;
      $display("FAIL start_while_busy: got %h lat %0d, want %h lat 18", obs_vec(), lat, e);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL ignored_start_no_op: got %0d active cycles, want 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] e;
    int lat = 1;
    exp_q.push_back(model(16'hFF00, 16'h0, 16'h0013, 1'b1, 1'b0));
    exp_q.push_back(model(16'h4321, 16'h0ABC, 16'hFFF3, 1'b1, 1'b1));
    @(negedge clk);
    a = 16'hFF00; ahigh = 16'h0; b = 16'h0013; signed_op = 1'b1; use32bit = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== e || lat != 18) begin
      errors++;
      $display("FAIL back_to_back_first: got %h lat %0d, want %h lat 18", obs_vec(), lat, e);
    end
    a = 16'h4321; ahigh = 16'h0ABC; b = 16'hFFF3; use32bit = 1'b1;
    @(posedge clk); #1; lat = 1; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_no_bubble: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    checks++;
    if (obs_vec() !== e || lat != 34) begin
      errors++;
      $display("FAIL back_to_back_second: got %h lat %0d, want %h lat 34", obs_vec(), lat, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
